// File: rtl/uart_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_loader
//  Purpose  : Parses a framed UART byte stream (sync, width, height, W*H
//             pixels, optional checksum) and writes the pixels into frame RAM
//             in row-major order. It signals completion or error to the
//             pipeline that follows.
//  Options  : UART_FRAME_CHECKSUM_EN - when defined, the packet carries a
//             trailing mod-256 checksum of the pixel bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_frame_loader #(
  parameter int         ADDR_W       = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 50000000
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]        o_Wr_Data,
  output logic [7:0]        o_Width,
  output logic [7:0]        o_Height,
  output logic              o_Busy,
  output logic              o_Frame_Done,
  output logic              o_Error
);

  localparam int               TMR_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CLKS - 1);
  localparam logic [32:0]      ADDR_SPAN = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WIDTH  = 3'd1,
    S_HEIGHT = 3'd2,
    S_PIXELS = 3'd3,
    S_DONE   = 3'd4,
`ifdef UART_FRAME_CHECKSUM_EN
    S_ERROR  = 3'd5,
    S_CHECK  = 3'd6
`else
    S_ERROR  = 3'd5
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          width_q, width_d;
  logic [7:0]          height_q, height_d;
  logic [15:0]         pix_cnt_q, pix_cnt_d;
  logic [15:0]         pix_idx_q, pix_idx_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic [15:0] w_product;
  logic        w_tmr_active;
  logic        w_expired;

  assign w_product    = 16'(width_q) * 16'(i_Rx_Byte);
`ifdef UART_FRAME_CHECKSUM_EN
  assign w_tmr_active = (state_q == S_WIDTH) || (state_q == S_HEIGHT) ||
                        (state_q == S_PIXELS) || (state_q == S_CHECK);
`else
  assign w_tmr_active = (state_q == S_WIDTH) || (state_q == S_HEIGHT) ||
                        (state_q == S_PIXELS);
`endif
  // A DV in the expiry cycle restarts the timer instead of aborting.
  assign w_expired    = w_tmr_active && !i_Rx_DV && (tmr_q == TMR_LAST);

  // Next-state, datapath and registered-output computation for the packet parser.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    pix_cnt_d = pix_cnt_q;
    pix_idx_d = pix_idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    tmr_d     = '0;
`ifdef UART_FRAME_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    if (w_tmr_active && !i_Rx_DV) begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          error_d = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
          state_d = S_WIDTH;
        end
      end
      S_WIDTH: begin
        if (i_Rx_DV) begin
          width_d = i_Rx_Byte;
          state_d = S_HEIGHT;
        end else if (w_expired) begin
          state_d = S_ERROR;
        end
      end
      S_HEIGHT: begin
        if (i_Rx_DV) begin
          height_d = i_Rx_Byte;
          if ((width_q == 8'd0) || (i_Rx_Byte == 8'd0) ||
              ({17'd0, w_product} > ADDR_SPAN)) begin
            state_d = S_ERROR;
          end else begin
            pix_cnt_d = w_product;
            pix_idx_d = 16'd0;
            wr_addr_d = '0;
            state_d   = S_PIXELS;
          end
        end else if (w_expired) begin
          state_d = S_ERROR;
        end
      end
      S_PIXELS: begin
        if (i_Rx_DV) begin
          wr_en_d   = 1'b1;
          wr_data_d = i_Rx_Byte;
          wr_addr_d = ADDR_W'(pix_idx_q);
          pix_idx_d = pix_idx_q + 16'd1;
`ifdef UART_FRAME_CHECKSUM_EN
          csum_d    = csum_q + i_Rx_Byte;
`endif
          if (pix_idx_q == (pix_cnt_q - 16'd1)) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end
        end else if (w_expired) begin
          state_d = S_ERROR;
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      S_CHECK: begin
        if (i_Rx_DV) begin
          state_d = (i_Rx_Byte == csum_q) ? S_DONE : S_ERROR;
        end else if (w_expired) begin
          state_d = S_ERROR;
        end
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      width_q   <= 8'd0;
      height_q  <= 8'd0;
      pix_cnt_q <= 16'd0;
      pix_idx_q <= 16'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      tmr_q     <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      pix_cnt_q <= pix_cnt_d;
      pix_idx_q <= pix_idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      tmr_q     <= tmr_d;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign o_Wr_En      = wr_en_q;
  assign o_Wr_Addr    = wr_addr_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Width      = width_q;
  assign o_Height     = height_q;
  assign o_Busy       = busy_q;
  assign o_Frame_Done = done_q;
  assign o_Error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_frame_loader
//  Purpose  : Self-checking bench for uart_frame_loader. Frames are described
//             as plain byte lists; the expected writes, completion and error
//             outcome are derived from the packet rules directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_loader;

  localparam int ADDR_W = 16;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        width;
  logic [7:0]        height;
  logic              busy;
  logic              frame_done;
  logic              error;

  uart_frame_loader #(
    .ADDR_W       (ADDR_W),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (100)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_DV      (rx_dv),
    .i_Rx_Byte    (rx_byte),
    .o_Wr_En      (wr_en),
    .o_Wr_Addr    (wr_addr),
    .o_Wr_Data    (wr_data),
    .o_Width      (width),
    .o_Height     (height),
    .o_Busy       (busy),
    .o_Frame_Done (frame_done),
    .o_Error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Observed writes and completion pulses.
  logic [15:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          wq_cyc[$];
  int          done_n = 0;
  int          done_cyc = 0;

  // Bytes following the header of the next frame.
  logic [7:0]  pix[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture DUT outputs half a cycle after they change.
  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(16'(wr_addr));
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_n = 0;
  endtask

  // Called at a negedge; returns at a negedge so gap 0 gives consecutive DVs.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int w, input int h, input int max_gap, input bit bad_csum);
    bit         valid;
    bit         exp_done;
    int         exp_n;
    int         dv_pix[$];
    int         last_dv;
    logic [7:0] sum;
    logic [7:0] wb;
    logic [7:0] hb;
    wb      = w[7:0];
    hb      = h[7:0];
    valid   = (w != 0) && (h != 0);
    sum     = 8'd0;
    last_dv = 0;
    clear_obs();
    send_byte(8'hA5, $urandom_range(0, max_gap));
    check_val("busy_after_sync", 32'(busy), 32'd1);
    check_val("error_cleared", 32'(error), 32'd0);
    send_byte(wb, $urandom_range(0, max_gap));
    send_byte(hb, $urandom_range(0, max_gap));
    foreach (pix[i]) begin
      sum = sum + pix[i];
      dv_pix.push_back(cyc);
      last_dv = cyc;
      send_byte(pix[i], $urandom_range(0, max_gap));
    end
    if (CSUM && valid) begin
      last_dv = cyc;
      send_byte(bad_csum ? (sum + 8'd1) : sum, 0);
    end
    repeat (4) @(negedge clk);

    exp_n    = valid ? pix.size() : 0;
    exp_done = valid && !bad_csum;
    check_val("write_count", 32'(wq_addr.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wq_addr.size(); i++) begin
      check_val("wr_addr", 32'(wq_addr[i]), 32'(i));
      check_val("wr_data", 32'(wq_data[i]), 32'(pix[i]));
      check_val("wr_latency", 32'(wq_cyc[i] - dv_pix[i]), 32'd1);
    end
    check_val("done_count", 32'(done_n), 32'(exp_done));
    if (exp_done && done_n == 1)
      check_val("done_latency", 32'(done_cyc - last_dv), 32'd2);
    check_val("error", 32'(error), 32'(!exp_done));
    check_val("busy_end", 32'(busy), 32'd0);
    check_val("width", 32'(width), 32'(wb));
    check_val("height", 32'(height), 32'(hb));
  endtask

  initial begin
    int w;
    int h;
    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'd0;
    repeat (3) @(negedge clk);
    check_val("rst_wr_en", 32'(wr_en), 32'd0);
    check_val("rst_addr", 32'(wr_addr), 32'd0);
    check_val("rst_width", 32'(width), 32'd0);
    check_val("rst_height", 32'(height), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(frame_done), 32'd0);
    check_val("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic 2x2 frame.
    pix = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(2, 2, 2, 1'b0);

`ifdef UART_FRAME_CHECKSUM_EN
    // Wrong checksum: pixels still written, error instead of done.
    pix = '{8'h05, 8'h06};
    send_frame(1, 2, 1, 1'b1);
`endif

    // Zero dimension followed by idle garbage.
    pix = '{8'h11, 8'h22};
    send_frame(0, 5, 1, 1'b0);

    // Timeout after a single pixel of a 3x1 frame.
    clear_obs();
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h01, 0);
    send_byte(8'h07, 0);
    repeat (90) @(negedge clk);
    check_val("tmo_error_early", 32'(error), 32'd0);
    check_val("tmo_busy_early", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    check_val("tmo_error", 32'(error), 32'd1);
    check_val("tmo_busy", 32'(busy), 32'd0);
    check_val("tmo_writes", 32'(wq_addr.size()), 32'd1);
    if (wq_addr.size() == 1) begin
      check_val("tmo_addr", 32'(wq_addr[0]), 32'd0);
      check_val("tmo_data", 32'(wq_data[0]), 32'h07);
    end

    // Reset in the middle of a frame.
    clear_obs();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h02, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check_val("mid_rst_addr", 32'(wr_addr), 32'd0);
    check_val("mid_rst_data", 32'(wr_data), 32'd0);
    check_val("mid_rst_width", 32'(width), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    send_byte(8'h77, 0);
    send_byte(8'h88, 3);
    check_val("post_rst_writes", 32'(wq_addr.size()), 32'd0);
    pix = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(2, 2, 0, 1'b0);

    // Back-to-back DVs with the sync value as pixel data.
    pix = '{8'hA5, 8'hA5, 8'hA5};
    send_frame(1, 3, 0, 1'b0);

    // Randomized frames, occasionally with a zero dimension or bad checksum.
    for (int k = 0; k < 14; k++) begin
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 5);
      if ($urandom_range(0, 6) == 0) w = 0;
      pix.delete();
      if (w == 0) begin
        pix.push_back(8'h3C);
      end else begin
        for (int i = 0; i < w * h; i++)
          pix.push_back(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
      end
      send_frame(w, h, $urandom_range(0, 3), CSUM && (w != 0) && ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
